// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode values, ALU
// operation codes, instruction classes, sequencer state encoding and the
// IR field positions the control unit looks at.
package cpu_pkg;

  // Opcode field position inside IR
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on alu_op
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;

  // Instruction classes; each class has its own execute-step recipe
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_IMM     = 3'd2,
    CLS_LDI     = 3'd3,
    CLS_LD      = 3'd4,
    CLS_ST      = 3'd5,
    CLS_NOP     = 3'd6,
    CLS_HALT    = 3'd7
  } op_class_t;

  // Sequencer states; T0..T7 encode their own step number
  typedef enum logic [3:0] {
    S_T0    = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_T3    = 4'd3,
    S_T4    = 4'd4,
    S_T5    = 4'd5,
    S_T6    = 4'd6,
    S_T7    = 4'd7,
    S_RESET = 4'd8,
    S_HALT  = 4'd15
  } state_t;

  // Debug step number for a state: RESET reports 0, HALT reports 15
  function automatic logic [3:0] state_step(state_t s);
    logic [3:0] r;
    if (s == S_RESET) r = 4'd0;
    else              r = s;
    return r;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction
// class and the ALU operation used in the class's compute step.
module op_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class,
  output logic [3:0]     alu_op
);

  // Opcode to class and ALU operation; anything unlisted is illegal
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    case (opcode)
      OPW'(OP_ADD):  begin op_class = CLS_R;    alu_op = ALU_ADD; end
      OPW'(OP_SUB):  begin op_class = CLS_R;    alu_op = ALU_SUB; end
      OPW'(OP_AND):  begin op_class = CLS_R;    alu_op = ALU_AND; end
      OPW'(OP_OR):   begin op_class = CLS_R;    alu_op = ALU_OR;  end
      OPW'(OP_SHR):  begin op_class = CLS_R;    alu_op = ALU_SHR; end
      OPW'(OP_SHL):  begin op_class = CLS_R;    alu_op = ALU_SHL; end
      OPW'(OP_ROR):  begin op_class = CLS_R;    alu_op = ALU_ROR; end
      OPW'(OP_ROL):  begin op_class = CLS_R;    alu_op = ALU_ROL; end
      OPW'(OP_ADDI): begin op_class = CLS_IMM;  alu_op = ALU_ADD; end
      OPW'(OP_ANDI): begin op_class = CLS_IMM;  alu_op = ALU_AND; end
      OPW'(OP_ORI):  begin op_class = CLS_IMM;  alu_op = ALU_OR;  end
      OPW'(OP_LDI):  begin op_class = CLS_LDI;  alu_op = ALU_ADD; end
      OPW'(OP_LD):   begin op_class = CLS_LD;   alu_op = ALU_ADD; end
      OPW'(OP_ST):   begin op_class = CLS_ST;   alu_op = ALU_ADD; end
      OPW'(OP_NOP):  begin op_class = CLS_NOP;  alu_op = ALU_ADD; end
      OPW'(OP_HALT): begin op_class = CLS_HALT; alu_op = ALU_ADD; end
      default:       begin op_class = CLS_ILLEGAL; alu_op = ALU_ADD; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired micro-step sequencer for the RISC CPU datapath.
// Steps through fetch (T0-T2) and per-class execute steps (T3-T7), driving
// every datapath enable, ALU operation and memory strobe as a Moore decode
// of the state register and IR.
// Optional feature macro: CONTROL_UNIT_STALL_EN -- when defined, memory
// steps wait for mem_ready; otherwise every memory step takes one cycle.
//
// Memory handshake: read/write act as the request and stay high for the
// whole memory step; mem_ready high in a cycle means the memory completes
// the transfer at that cycle's closing edge, and only then does the
// sequencer leave the step. mem_ready is ignored outside memory steps.
//
// IR is loaded at the end of T2, so the opcode is only trusted from the
// cycle after T2. That cycle is the dispatch slot: for executing classes it
// is T3, for nop/illegal it behaves as T0 of the next fetch, and for halt
// it is already the halted state.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int STEPW = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             pci,
  output logic             pco,
  output logic             iri,
  output logic             mari,
  output logic             mdri,
  output logic             mdro,
  output logic             ryi,
  output logic             zi,
  output logic             zlo_o,
  output logic             inc_pc,
  output logic             read,
  output logic             write,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rin,
  output logic             rout,
  output logic             ba_out,
  output logic             c_out,
  output logic [3:0]       alu_op,
  output logic             run,
  output logic             illegal,
  output logic [STEPW-1:0] step
);

  state_t         state;
  state_t         eff_state;
  op_class_t      op_class;
  logic [3:0]     dec_alu;
  logic [OPW-1:0] opcode;
  logic           hold;
  logic           unused_bits;

  assign opcode = ir[OP_MSB -: OPW];

  op_decode #(.OPW(OPW)) u_op_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .alu_op   (dec_alu)
  );

  // Dispatch slot collapses to T0 (nop/illegal) or HALT (halt)
  always_comb begin
    eff_state = state;
    if (state == S_T3) begin
      case (op_class)
        CLS_NOP, CLS_ILLEGAL: eff_state = S_T0;
        CLS_HALT:             eff_state = S_HALT;
        default:              eff_state = S_T3;
      endcase
    end
  end

`ifdef CONTROL_UNIT_STALL_EN
  logic mem_step;

  // Hold a memory step until the memory reports completion
  always_comb begin
    mem_step = (eff_state == S_T1)
            || (eff_state == S_T6 && op_class == CLS_LD)
            || (eff_state == S_T7 && op_class == CLS_ST);
    hold     = mem_step && !mem_ready;
  end
  assign unused_bits = ^ir[OP_LSB-1:0];
`else
  assign hold        = 1'b0;
  assign unused_bits = ^{ir[OP_LSB-1:0], mem_ready};
`endif

  // Step sequencer: one step per cycle, async abort to RESET
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
    end else if (!hold) begin
      case (eff_state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_T4;
        S_T4:    state <= S_T5;
        S_T5:    state <= (op_class == CLS_LD || op_class == CLS_ST) ? S_T6 : S_T0;
        S_T6:    state <= S_T7;
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Moore decode of enables, strobes and ALU operation per step and class
  always_comb begin
    pci    = 1'b0; pco    = 1'b0; iri    = 1'b0; mari   = 1'b0;
    mdri   = 1'b0; mdro   = 1'b0; ryi    = 1'b0; zi     = 1'b0;
    zlo_o  = 1'b0; inc_pc = 1'b0; read   = 1'b0; write  = 1'b0;
    gra    = 1'b0; grb    = 1'b0; grc    = 1'b0; rin    = 1'b0;
    rout   = 1'b0; ba_out = 1'b0; c_out  = 1'b0; alu_op = ALU_ADD;
    case (eff_state)
      S_T0: begin
        pco = 1'b1; mari = 1'b1; inc_pc = 1'b1; zi = 1'b1;
      end
      S_T1: begin
        zlo_o = 1'b1; pci = 1'b1; read = 1'b1; mdri = 1'b1;
      end
      S_T2: begin
        mdro = 1'b1; iri = 1'b1;
      end
      S_T3: begin
        grb = 1'b1; ryi = 1'b1;
        if (op_class == CLS_R || op_class == CLS_IMM) rout   = 1'b1;
        else                                          ba_out = 1'b1;
      end
      S_T4: begin
        zi     = 1'b1;
        alu_op = dec_alu;
        if (op_class == CLS_R) begin
          grc = 1'b1; rout = 1'b1;
        end else begin
          c_out = 1'b1;
        end
      end
      S_T5: begin
        zlo_o = 1'b1;
        if (op_class == CLS_LD || op_class == CLS_ST) begin
          mari = 1'b1;
        end else begin
          gra = 1'b1; rin = 1'b1;
        end
      end
      S_T6: begin
        mdri = 1'b1;
        if (op_class == CLS_ST) begin
          gra = 1'b1; rout = 1'b1;
        end else begin
          read = 1'b1;
        end
      end
      S_T7: begin
        if (op_class == CLS_ST) begin
          write = 1'b1;
        end else begin
          mdro = 1'b1; gra = 1'b1; rin = 1'b1;
        end
      end
      default: begin
        alu_op = ALU_ADD;
      end
    endcase
  end

  // Status: run, illegal-opcode pulse in the dispatch slot, debug step
  always_comb begin
    run     = (state != S_RESET) && (eff_state != S_HALT);
    illegal = (state == S_T3) && (op_class == CLS_ILLEGAL);
    step    = STEPW'(state_step(eff_state));
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired micro-step sequencer for the RISC CPU. Sits directly upstream of `datapath`: decodes the instruction held in IR and drives every register in/out enable, ALU operation and memory strobe the datapath consumes, stepping through fetch (T0–T2) and per-class execute steps (T3–T7). It replaces the hand-sequenced enables used during bring-up with one FSM advanced by the datapath clock.

## Interface
Parameters:
- `OPW`, 5, opcode width (`ir[31:27]`)
- `STEPW`, 4, width of debug `step` output

Ports:
- `clock`  in  1  system clock, rising edge
- `clear`  in  1  asynchronous, active-low reset
- `ir`  in  32  IR contents from datapath
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pci`, `pco`, `iri`, `mari`, `mdri`, `mdro`, `ryi`, `zi`, `zlo_o`  out  1 each  datapath enables
- `inc_pc`  out  1  ALU computes PC+1 into Z
- `read`, `write`  out  1  memory strobes (`read` also selects memory into MDR)
- `gra`, `grb`, `grc`, `rin`, `rout`, `ba_out`  out  1  register-file select/enable; `ba_out` reads R0 as 0
- `c_out`  out  1  drives sign-extended `ir[18:0]` onto bus
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror, 7 rol
- `run`  out  1  high unless halted
- `illegal`  out  1  one-cycle pulse on undefined opcode
- `step`  out  STEPW  current step (T0=0 … T7=7, HALT=15)

## Operation
- States: RESET, T0–T7, HALT. Moore outputs decoded from state register and `ir`; all outputs 0 except as listed.
- Fetch: T0 `pco mari inc_pc zi`; T1 `zlo_o pci read mdri`; T2 `mdro iri`.
- R-type (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010): T3 `grb rout ryi`; T4 `grc rout zi alu_op=op`; T5 `zlo_o gra rin` → T0.
- Immediate (addi 01100, andi 01101, ori 01110, ldi 00001 as add): T3 `grb rout ryi` (`ba_out` instead of `rout` for ldi); T4 `c_out zi alu_op`; T5 `zlo_o gra rin` → T0.
- ld 00000: T3 `grb ba_out ryi`; T4 `c_out zi alu_op=0`; T5 `zlo_o mari`; T6 `read mdri`; T7 `mdro gra rin` → T0.
- st 00010: T3–T5 as ld; T6 `gra rout mdri`; T7 `write` → T0.
- nop 11010: T2 → T0. halt 11011: T2 → HALT; HALT holds, `run`=0, all enables 0, until reset.
- Other opcodes: T2 → T0, `illegal`=1 during T3-equivalent cycle (first cycle of next T0).

## Timing
- `clear` low: state RESET asynchronously; every output 0, `run`=0, `step`=0. First rising edge with `clear` high → T0, `run`=1.
- One step per cycle; enables valid the whole cycle, datapath captures at the closing edge.
- `ir` sampled from T3 onward (IR written at end of T2).
- Memory steps (T1, ld T6, st T7): with stall enabled, state holds and strobes remain high until a cycle with `mem_ready`=1; advance on that edge. `mem_ready` ignored elsewhere.
- Latency: nop 3 cycles, R/imm 6, ld/st 8 (plus stall cycles).
- Reset mid-instruction: immediate abort, no further strobes.

## Configuration
- `CONTROL_UNIT_STALL_EN` defined: memory steps wait on `mem_ready` as above.
- Undefined: every memory step takes exactly one cycle; `mem_ready` unused.

## Structure
- `cpu_pkg`: opcode constants, `alu_op` codes, state encoding, IR field positions.
- Sub-module `op_decode`: combinational opcode → class (R, IMM, LD, LDI, ST, NOP, HALT, ILLEGAL) plus `alu_op`.

## Test plan
- Hold `clear` low 3 cycles mid-sequence → all outputs 0, `step`=0; release → T0 with `pco mari inc_pc zi`.
- `ir`=0x28918000 (and R1,R2,R3) → T3 `grb rout ryi`, T4 `grc rout zi alu_op=2`, T5 `zlo_o gra rin`, back to T0 at cycle 6.
- ld, `mem_ready` low 2 cycles in T6 (stall enabled) → `read mdri` held 3 cycles, T7 `mdro gra rin`.
- st 0x10800005 → T6 `gra rout mdri`, T7 `write`, `read`=0 throughout T3–T7.
- `ir`=0xD8000000 (halt) → HALT, `run`=0, `step`=15, stays for 20 cycles.
- `ir`=0xF8000000 (undefined) → single `illegal` pulse, fetch restarts, no `rin`.
